// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer: snapshots the three PSG channel levels on CE and forms an
// L/R pair one channel per cycle (IDLE -> SUM_A -> SUM_B -> SUM_C -> OUT).
// The pair is presented as 10-bit unsigned PCM with a one-cycle valid strobe.
// It also drives first-order sigma-delta 1-bit DAC outputs for each side.
// Optional build macro: PSG_BEEPER_MIX_EN adds a BEEPER input. That input is
// snapshotted with the channels and adds 192 to both sides of the sample.
module psg_stereo_mixer #(
    // Must equal the PCM width (10); no other value is supported.
    parameter int SD_BITS = 10
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               CE,
    input  logic [7:0]         CH_A,
    input  logic [7:0]         CH_B,
    input  logic [7:0]         CH_C,
    input  logic [1:0]         STEREO,
`ifdef PSG_BEEPER_MIX_EN
    input  logic               BEEPER,
`endif
    output logic [SD_BITS-1:0] AUDIO_L,
    output logic [SD_BITS-1:0] AUDIO_R,
    output logic               SAMPLE_VALID,
    output logic               OVERRUN,
    output logic               DAC_L,
    output logic               DAC_R
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM_A,
        S_SUM_B,
        S_SUM_C,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         snap_a_q, snap_a_d;
    logic [7:0]         snap_b_q, snap_b_d;
    logic [7:0]         snap_c_q, snap_c_d;
    logic [1:0]         snap_mode_q, snap_mode_d;
    logic [SD_BITS-1:0] acc_l_q, acc_l_d;
    logic [SD_BITS-1:0] acc_r_q, acc_r_d;
    logic [SD_BITS-1:0] audio_l_q, audio_l_d;
    logic [SD_BITS-1:0] audio_r_q, audio_r_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [SD_BITS:0]   sd_l_q, sd_l_d;
    logic [SD_BITS:0]   sd_r_q, sd_r_d;

    // Contribution of the channel being summed this cycle, and the beeper offset.
    logic [7:0]         cur_ch;
    logic [1:0]         w_l, w_r;
    logic [SD_BITS-1:0] term_l, term_r, sum_l, sum_r, beep_add;

`ifdef PSG_BEEPER_MIX_EN
    logic snap_beep_q, snap_beep_d;
    assign beep_add = snap_beep_q ? SD_BITS'(192) : '0;
`else
    assign beep_add = '0;
`endif

    // Channel level times a weight of 0, 1 or 2 (a weight of 2 is a shift left by 1).
    function automatic logic [SD_BITS-1:0] weigh(input logic [7:0] v, input logic [1:0] w);
        case (w)
            2'd1:    weigh = {2'b00, v};
            2'd2:    weigh = {1'b0, v, 1'b0};
            default: weigh = '0;
        endcase
    endfunction

    // Pick the current channel and its (left, right) weights for the latched pan mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cur_ch = snap_c_q;
        w_l    = 2'd1;
        w_r    = 2'd1;
        case (state_q)
            S_SUM_A: cur_ch = snap_a_q;
            S_SUM_B: cur_ch = snap_b_q;
            default: cur_ch = snap_c_q;
        endcase
        if (snap_mode_q == 2'b01 || snap_mode_q == 2'b10) begin
            // In both stereo modes A is hard left. In ABC, B is centre and C right.
            // In ACB, C is centre and B right.
            if (state_q == S_SUM_A) begin
                w_l = 2'd2;
                w_r = 2'd0;
            end else if ((state_q == S_SUM_B) == (snap_mode_q == 2'b10)) begin
                w_l = 2'd0;
                w_r = 2'd2;
            end
        end
        term_l = weigh(cur_ch, w_l);
        term_r = weigh(cur_ch, w_r);
        sum_l  = acc_l_q + term_l;
        sum_r  = acc_r_q + term_r;
    end

    // Sequencer: snapshot on CE in IDLE, accumulate one channel per state, publish.
    always_comb begin
        state_d     = state_q;
        snap_a_d    = snap_a_q;
        snap_b_d    = snap_b_q;
        snap_c_d    = snap_c_q;
        snap_mode_d = snap_mode_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        audio_l_d   = audio_l_q;
        audio_r_d   = audio_r_q;
        valid_d     = 1'b0;
`ifdef PSG_BEEPER_MIX_EN
        snap_beep_d = snap_beep_q;
`endif
        // A CE while a sample is in flight is dropped and remembered until reset.
        overrun_d   = overrun_q | (CE && state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (CE) begin
                    snap_a_d    = CH_A;
                    snap_b_d    = CH_B;
                    snap_c_d    = CH_C;
                    snap_mode_d = STEREO;
`ifdef PSG_BEEPER_MIX_EN
                    snap_beep_d = BEEPER;
`endif
                    acc_l_d     = '0;
                    acc_r_d     = '0;
                    state_d     = S_SUM_A;
                end
            end
            S_SUM_A, S_SUM_B: begin
                acc_l_d = sum_l;
                acc_r_d = sum_r;
                state_d = (state_q == S_SUM_A) ? S_SUM_B : S_SUM_C;
            end
            S_SUM_C: begin
                // The output registers load as the FSM enters OUT.
                // This makes the new pair and the strobe visible during the OUT cycle.
                acc_l_d   = sum_l;
                acc_r_d   = sum_r;
                audio_l_d = sum_l + beep_add;
                audio_r_d = sum_r + beep_add;
                valid_d   = 1'b1;
                state_d   = S_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // First-order sigma-delta per side: the carry out of the 10-bit sum is the DAC bit.
    always_comb begin
        sd_l_d = {1'b0, sd_l_q[SD_BITS-1:0]} + {1'b0, audio_l_q};
        sd_r_d = {1'b0, sd_r_q[SD_BITS-1:0]} + {1'b0, audio_r_q};
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            snap_a_q    <= '0;
            snap_b_q    <= '0;
            snap_c_q    <= '0;
            snap_mode_q <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            sd_l_q      <= '0;
            sd_r_q      <= '0;
`ifdef PSG_BEEPER_MIX_EN
            snap_beep_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            snap_a_q    <= snap_a_d;
            snap_b_q    <= snap_b_d;
            snap_c_q    <= snap_c_d;
            snap_mode_q <= snap_mode_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            sd_l_q      <= sd_l_d;
            sd_r_q      <= sd_r_d;
`ifdef PSG_BEEPER_MIX_EN
            snap_beep_q <= snap_beep_d;
`endif
        end
    end

    assign AUDIO_L      = audio_l_q;
    assign AUDIO_R      = audio_r_q;
    assign SAMPLE_VALID = valid_q;
    assign OVERRUN      = overrun_q;
    assign DAC_L        = sd_l_q[SD_BITS];
    assign DAC_R        = sd_r_q[SD_BITS];

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Testbench for psg_stereo_mixer. The stimulus pushes the expected L/R pair,
// computed from the panning rules, into a queue. A monitor pops an entry on
// each SAMPLE_VALID and checks the values and the latency.
module tb_psg_stereo_mixer;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       CE;
    logic [7:0] CH_A, CH_B, CH_C;
    logic [1:0] STEREO;
`ifdef PSG_BEEPER_MIX_EN
    logic       BEEPER;
`endif
    logic [9:0] AUDIO_L, AUDIO_R;
    logic       SAMPLE_VALID, OVERRUN, DAC_L, DAC_R;

    psg_stereo_mixer dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .CE(CE),
        .CH_A(CH_A),
        .CH_B(CH_B),
        .CH_C(CH_C),
        .STEREO(STEREO),
`ifdef PSG_BEEPER_MIX_EN
        .BEEPER(BEEPER),
`endif
        .AUDIO_L(AUDIO_L),
        .AUDIO_R(AUDIO_R),
        .SAMPLE_VALID(SAMPLE_VALID),
        .OVERRUN(OVERRUN),
        .DAC_L(DAC_L),
        .DAC_R(DAC_R)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int l;
        int r;
        int ce_cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int last_l   = 0;
    int last_r   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference mix: weights per pan mode applied with plain integer arithmetic.
    function automatic void mix(input int a, input int b, input int c, input int mode,
                                input int beep, output int l, output int r);
        case (mode)
            1:       begin l = 2*a + b; r = b + 2*c; end
            2:       begin l = 2*a + c; r = c + 2*b; end
            default: begin l = a + b + c; r = a + b + c; end
        endcase
        l += 192 * beep;
        r += 192 * beep;
    endfunction

    // Monitor: checks each published sample, holds between samples and reset values.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            check("reset_audio_l", AUDIO_L, 0);
            check("reset_audio_r", AUDIO_R, 0);
            check("reset_valid", SAMPLE_VALID, 0);
            check("reset_overrun", OVERRUN, 0);
            check("reset_dac", {DAC_L, DAC_R}, 0);
            last_l = 0;
            last_r = 0;
        end else if (SAMPLE_VALID) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", SAMPLE_VALID, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("audio_l", AUDIO_L, e.l);
                check("audio_r", AUDIO_R, e.r);
                check("latency", cyc - e.ce_cyc, 4);
                last_l = e.l;
                last_r = e.r;
            end
        end else begin
            check("hold_l", AUDIO_L, last_l);
            check("hold_r", AUDIO_R, last_r);
        end
    end

    // Drive one CE with the given snapshot. The channels are then scrambled to
    // show the sample in flight is unaffected. Takes two clocks.
    task automatic issue(input int a, input int b, input int c, input int mode,
                         input int beep, input bit expect_out);
        int l, r, be;
        @(posedge CLK); #1;
        CH_A = 8'(a); CH_B = 8'(b); CH_C = 8'(c); STEREO = 2'(mode);
        be = 0;
`ifdef PSG_BEEPER_MIX_EN
        BEEPER = beep[0];
        be = beep & 1;
`endif
        CE = 1'b1;
        mix(a, b, c, mode, be, l, r);
        if (expect_out) sb_q.push_back('{l, r, cyc});
        @(posedge CLK); #1;
        CE = 1'b0;
        CH_A = 8'($urandom); CH_B = 8'($urandom); CH_C = 8'($urandom);
        STEREO = 2'($urandom);
`ifdef PSG_BEEPER_MIX_EN
        BEEPER = 1'($urandom);
`endif
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int ones_l, ones_r;

    initial begin
        RESET_N = 1'b0;
        CE = 1'b0;
        CH_A = '0; CH_B = '0; CH_C = '0; STEREO = '0;
`ifdef PSG_BEEPER_MIX_EN
        BEEPER = 1'b0;
`endif
        wait_clks(3);
        RESET_N = 1'b1;

        // Idle: no CE means no strobe, zero PCM and a silent DAC.
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            ones_l += int'(DAC_L);
            ones_r += int'(DAC_R);
        end
        check("idle_dac_l_ones", ones_l, 0);
        check("idle_dac_r_ones", ones_r, 0);
        check("idle_overrun", OVERRUN, 0);

        // Directed pans at the minimum CE spacing (two clocks in issue, three extra).
        issue(255, 0, 0, 1, 0, 1);   wait_clks(3);
        issue(0, 100, 50, 1, 0, 1);  wait_clks(3);
        issue(255, 255, 255, 0, 0, 1); wait_clks(3);
        issue(10, 20, 30, 2, 0, 1);  wait_clks(3);
        issue(255, 255, 255, 3, 0, 1); wait_clks(3);
        issue(0, 0, 0, 2, 0, 1);     wait_clks(3);

        // Randomized samples with spacing of 5 to 9 clocks.
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 1)), 1);
            wait_clks(int'($urandom_range(3, 7)));
        end
        wait_clks(4);
        check("no_overrun_spaced", OVERRUN, 0);

        // Sigma-delta density: L = 2*200 + 112 = 512, R = 112.
        issue(200, 112, 0, 1, 0, 1);
        wait_clks(8);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge CLK);
            ones_l += int'(DAC_L);
            ones_r += int'(DAC_R);
        end
        check("density_l", ones_l, 512);
        check("density_r", ones_r, 112);

        // Overrun: a second CE two clocks later is dropped and raises the sticky flag.
        issue(7, 9, 11, 1, 0, 1);      // CE in cycle k, returns in cycle k+1
        @(posedge CLK); #1;            // cycle k+2
        CH_A = 8'd200; CH_B = 8'd200; CH_C = 8'd200; STEREO = 2'd0;
        CE = 1'b1;
        @(negedge CLK);
        check("overrun_before", OVERRUN, 0);
        @(posedge CLK); #1;            // cycle k+3
        CE = 1'b0;
        @(negedge CLK);
        check("overrun_set", OVERRUN, 1);
        wait_clks(20);
        check("overrun_sticky", OVERRUN, 1);
        check("overrun_single_sample", sb_q.size(), 0);

        // Reset mid-sample: no strobe, and everything returns to zero.
        issue(100, 100, 100, 0, 0, 0); // CE in cycle k; now in cycle k+1
        @(posedge CLK); #1;            // cycle k+2
        RESET_N = 1'b0;
        wait_clks(2);
        RESET_N = 1'b1;
        wait_clks(12);
        check("post_reset_audio_l", AUDIO_L, 0);
        check("post_reset_overrun", OVERRUN, 0);

`ifdef PSG_BEEPER_MIX_EN
        // Beeper only: both sides equal 192.
        issue(0, 0, 0, 1, 1, 1);
        wait_clks(6);
`endif

        // Drain: every expected sample must have been presented.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge CLK);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psg_stereo_mixer.md
Name: psg_stereo_mixer

Overview:
- Downstream consumer of the PSG's three 8-bit channel outputs (A/B/C).
- Snapshots the channels on a sample enable and forms a stereo L/R pair using a selectable panning mode, in a sequential one-channel-per-cycle accumulation.
- Presents the pair as parallel 10-bit PCM with a valid strobe, and drives per-side first-order sigma-delta 1-bit DAC outputs for FPGA pins.

Parameters:
- SD_BITS, 10, sigma-delta accumulator data width. Fixed at 10 and must equal the PCM width; no other value is supported.

Ports:
- CLK  in  1  system clock, same domain as the PSG.
- RESET_N  in  1  asynchronous, active-low reset.
- CE  in  1  sample enable, one-CLK pulse.
- CH_A  in  8  PSG channel A level.
- CH_B  in  8  PSG channel B level.
- CH_C  in  8  PSG channel C level.
- STEREO  in  2  panning mode: 00 mono, 01 ABC, 10 ACB, 11 mono.
- AUDIO_L  out  10  left PCM, unsigned.
- AUDIO_R  out  10  right PCM, unsigned.
- SAMPLE_VALID  out  1  one-CLK pulse when AUDIO_L/R update.
- OVERRUN  out  1  sticky flag: a CE arrived while busy.
- DAC_L  out  1  left sigma-delta bitstream.
- DAC_R  out  1  right sigma-delta bitstream.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - AUDIO_L = AUDIO_R = 0; SAMPLE_VALID = 0; OVERRUN = 0; DAC_L = DAC_R = 0.
  - Sigma-delta accumulators = 0; FSM = IDLE; snapshot and sum accumulators = 0.
- FSM states, one state per CLK: IDLE -> SUM_A -> SUM_B -> SUM_C -> OUT -> IDLE.
- IDLE: CE=1 latches CH_A/CH_B/CH_C and STEREO into snapshot registers, clears acc_l/acc_r (10-bit), and moves to SUM_A. Otherwise stays in IDLE.
- Weights (wL, wR) per channel:
  - Mono (00/11): A(1,1), B(1,1), C(1,1).
  - ABC (01): A(2,0), B(1,1), C(0,2).
  - ACB (10): A(2,0), C(1,1), B(0,2).
- SUM_A, SUM_B, SUM_C each add that channel's snapshot times its weight to acc_l and acc_r. Weight 2 is a left shift by 1.
- Width: maximum sum is 3*255 = 765, so 10 bits never overflow and no saturation is needed.
- OUT: AUDIO_L <= acc_l, AUDIO_R <= acc_r, SAMPLE_VALID = 1 for this cycle only.
- Latency: CE at cycle n gives SAMPLE_VALID and new AUDIO values visible from cycle n+4. Minimum CE spacing is 5 CLK.
- CE in any state other than IDLE: the CE is ignored, the current sample completes unchanged, and OVERRUN is set to 1. OVERRUN clears only on reset.
- Simultaneous CE and OUT: the CE is ignored and flagged. The FSM is in OUT, not IDLE.
- Changes on CH_x or STEREO after the snapshot have no effect on the sample in progress.
- AUDIO_L/R hold their value between samples.
- Sigma-delta runs every CLK, independent of CE, one instance per side:
  - acc <= {1'b0, acc[9:0]} + AUDIO (11-bit).
  - DAC = acc[10], registered.
  - Over any 1024 consecutive CLKs with constant AUDIO = v, DAC is high for exactly v cycles.
  - An AUDIO update changes the density from the next CLK onward; the accumulator is not reset on update.
- Reset asserted mid-sequence: the FSM returns to IDLE, no SAMPLE_VALID is produced, and outputs go to their reset values immediately.

Optional Feature:
- Macro: PSG_BEEPER_MIX_EN.
- When defined:
  - Adds input port BEEPER (1 bit), latched with the snapshot on CE.
  - OUT state adds 192 to both acc_l and acc_r before output when the latched BEEPER = 1.
  - Maximum result is 765 + 192 = 957, which still fits 10 bits with no clipping.
- When undefined: the BEEPER port does not exist and behaviour is exactly as above.

Test Plan:
- Reset then idle: hold RESET_N low 3 CLK, release, no CE for 100 CLK -> AUDIO_L = AUDIO_R = 0, DAC_L = DAC_R = 0 throughout, SAMPLE_VALID never pulses.
- ABC pan: STEREO=01, A=255, B=0, C=0, CE at cycle 10 -> SAMPLE_VALID only at cycle 14, AUDIO_L = 510, AUDIO_R = 0. Then A=0, B=100, C=50, CE -> L = 100, R = 200.
- Mono full scale: STEREO=00, A=B=C=255, CE -> AUDIO_L = AUDIO_R = 765. ACB with A=10, B=20, C=30 -> L = 50, R = 70.
- Overrun: CE at cycles 0 and 2 -> one SAMPLE_VALID at cycle 4, result from the cycle-0 snapshot, OVERRUN = 1 from cycle 3 and stays set. CE spaced 5 CLK apart -> no OVERRUN.
- Sigma-delta density: force AUDIO_L = 512 via a mono sample (A=B=C chosen to give 512 is impossible, so use ABC A=256/2... use STEREO=01, A=200, B=112, C=0 -> L = 512) -> exactly 512 ones in DAC_L per 1024 CLK window. AUDIO_R = 112 -> exactly 112 ones.
- Reset mid-sample: CE, then RESET_N low at cycle 2 -> no SAMPLE_VALID, outputs 0. With PSG_BEEPER_MIX_EN: BEEPER=1, all channels 0, CE -> L = R = 192.
